// File: rtl/jtag_debug_sys_pio_rd_arbiter.sv
// Round-robin read arbiter sharing the JTAG debug system's 32-bit PIO input slave
// between NUM_REQ Avalon-MM requesters; returns are tagged through a two-stage pipeline.
module jtag_debug_sys_pio_rd_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     m_read_i,
    input  logic [2*NUM_REQ-1:0]   m_address_i,
    output logic [NUM_REQ-1:0]     m_waitrequest_o,
    output logic [31:0]            m_readdata_o,
    output logic [NUM_REQ-1:0]     m_readdatavalid_o,
    output logic [1:0]             s_address_o,
    input  logic [31:0]            s_readdata_i
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] tag1_q, tag1_d;
    logic [IW-1:0] tag2_q;
    logic          v1_q, v1_d;
    logic          v2_q;
    logic [1:0]    s_addr_q, s_addr_d;

    logic          grant_vld;
    logic [IW-1:0] grant_idx;
    int            cand;

    // Search upward from rr_ptr with wrap; nothing is granted while reset is held.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_vld && reset_n && m_read_i[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        s_addr_d = s_addr_q;
        tag1_d   = tag1_q;
        v1_d     = 1'b0;
        rr_ptr_d = rr_ptr_q;
        if (grant_vld) begin
            s_addr_d = m_address_i[{grant_idx, 1'b0} +: 2];
            tag1_d   = grant_idx;
            v1_d     = 1'b1;
            rr_ptr_d = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
            tag1_q   <= '0;
            tag2_q   <= '0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            s_addr_q <= 2'b00;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            tag1_q   <= tag1_d;
            tag2_q   <= tag1_q;
            v1_q     <= v1_d;
            v2_q     <= v1_q;
            s_addr_q <= s_addr_d;
        end
    end

    // Stage 2 lines up with the slave's registered data, so the tag selects the owner.
    always_comb begin
        m_waitrequest_o   = '1;
        m_readdatavalid_o = '0;
        if (grant_vld) begin
            m_waitrequest_o[grant_idx] = 1'b0;
        end
        if (v2_q) begin
            m_readdatavalid_o[tag2_q] = 1'b1;
        end
    end

    assign m_readdata_o = s_readdata_i;
    assign s_address_o  = s_addr_q;

endmodule

// File: tb/tb_jtag_debug_sys_pio_rd_arbiter.sv
// Bench for jtag_debug_sys_pio_rd_arbiter: vector table with expected grants plus a
// return scoreboard; a behavioural PIO slave answers on the shared address bus.
module tb_jtag_debug_sys_pio_rd_arbiter;

    logic        clk;
    logic        reset_n;
    logic [3:0]  mRead;
    logic [7:0]  mAddress;
    logic [3:0]  mWaitrequest;
    logic [31:0] mReaddata;
    logic [3:0]  mReaddatavalid;
    logic [1:0]  sAddress;
    logic [31:0] sReaddata;
    logic [31:0] inPort;

    jtag_debug_sys_pio_rd_arbiter #(.NUM_REQ(4)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .m_read_i          (mRead),
        .m_address_i       (mAddress),
        .m_waitrequest_o   (mWaitrequest),
        .m_readdata_o      (mReaddata),
        .m_readdatavalid_o (mReaddatavalid),
        .s_address_o       (sAddress),
        .s_readdata_i      (sReaddata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PIO data slave: one-cycle registered read, in_port only at address 0
    always @(posedge clk) begin
        sReaddata <= (sAddress == 2'd0) ? inPort : 32'h0;
    end

    typedef struct {
        logic        rstn;
        logic [3:0]  rd;
        logic [7:0]  addr;
        logic [31:0] inp;
        int          expGrant;
    } vec_t;

    typedef struct {
        int          due;
        int          req;
        logic [1:0]  addr;
        logic [31:0] data;
    } sb_t;

    vec_t        vecs[$];
    sb_t         sbq[$];
    int          testsRun = 0;
    int          testsFailed = 0;
    int          cycle = 0;
    bit          checksOn = 1'b0;
    logic [1:0]  expSAddr = 2'd0;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s cycle %0d: got %h, expected %h", name, cycle, got, exp);
        end
    endtask

    task automatic addVec(input logic rstn, input logic [3:0] rd, input logic [7:0] addr,
                          input logic [31:0] inp, input int expGrant);
        vec_t v;
        v.rstn = rstn; v.rd = rd; v.addr = addr; v.inp = inp; v.expGrant = expGrant;
        vecs.push_back(v);
    endtask

    // One bus cycle: drive after the rising edge, check at the falling edge, then
    // advance the scoreboard to what the next rising edge will commit.
    task automatic applyStimulus(input logic rstn, input logic [3:0] rd, input logic [7:0] addr,
                                 input logic [31:0] inp, input int expGrant);
        logic [3:0]  expWait;
        logic [3:0]  expValid;
        logic [31:0] expData;
        bit          hasRet;
        sb_t         e;
        @(posedge clk);
        #1;
        reset_n  = rstn;
        mRead    = rd;
        mAddress = addr;
        inPort   = inp;
        @(negedge clk);
        expWait = 4'hF;
        if (rstn && expGrant >= 0) expWait[expGrant] = 1'b0;
        expValid = 4'h0;
        expData  = 32'h0;
        hasRet   = 1'b0;
        if (sbq.size() > 0 && sbq[0].due == cycle) begin
            e = sbq.pop_front();
            expValid[e.req] = 1'b1;
            expData = e.data;
            hasRet = 1'b1;
        end
        if (checksOn) begin
            checkOutput("waitrequest", {28'h0, mWaitrequest}, {28'h0, expWait});
            checkOutput("s_address", {30'h0, sAddress}, {30'h0, expSAddr});
            checkOutput("readdatavalid", {28'h0, mReaddatavalid}, {28'h0, expValid});
            if (hasRet) checkOutput("readdata", mReaddata, expData);
        end
        foreach (sbq[i]) begin
            if (sbq[i].due == cycle + 1) sbq[i].data = (sbq[i].addr == 2'd0) ? inp : 32'h0;
        end
        if (!rstn) begin
            sbq.delete();
            expSAddr = 2'd0;
        end else if (expGrant >= 0) begin
            e.due  = cycle + 2;
            e.req  = expGrant;
            e.addr = 2'((addr >> (2 * expGrant)) & 8'h3);
            e.data = 32'h0;
            sbq.push_back(e);
            expSAddr = e.addr;
        end
        cycle++;
    endtask

    initial begin
        reset_n  = 1'b0;
        mRead    = 4'h0;
        mAddress = 8'h0;
        inPort   = 32'h0;

        // reset, then single read by requester 2 at address 0
        addVec(0, 4'b1111, 8'h00, 32'h0, -1);
        addVec(0, 4'b1111, 8'h00, 32'h0, -1);
        addVec(1, 4'b0000, 8'h00, 32'hDEADBEEF, -1);
        addVec(1, 4'b0100, 8'h00, 32'hDEADBEEF, 2);
        for (int i = 0; i < 3; i++) addVec(1, 4'b0000, 8'h00, 32'hDEADBEEF, -1);
        // requester 0 at address 1 returns zero
        addVec(1, 4'b0001, 8'h01, 32'hFFFFFFFF, 0);
        for (int i = 0; i < 3; i++) addVec(1, 4'b0000, 8'h00, 32'hFFFFFFFF, -1);
        // all four requesting after reset
        addVec(0, 4'b1111, 8'hE4, 32'hA5A5A5A5, -1);
        for (int i = 0; i < 8; i++) addVec(1, 4'b1111, 8'hE4, 32'hA5A5A5A5, i % 4);
        for (int i = 0; i < 2; i++) addVec(1, 4'b0000, 8'h00, 32'hA5A5A5A5, -1);
        // round-robin skip between requesters 1 and 3
        addVec(1, 4'b1000, 8'h00, 32'h0000C0DE, 3);
        addVec(1, 4'b1010, 8'h00, 32'h0000C0DE, 1);
        addVec(1, 4'b1010, 8'h00, 32'h0000C0DE, 3);
        addVec(1, 4'b1010, 8'h00, 32'h0000C0DE, 1);
        for (int i = 0; i < 2; i++) addVec(1, 4'b0000, 8'h00, 32'h0000C0DE, -1);
        // requester 1 withdraws; pointer must not move on the idle cycle
        addVec(1, 4'b1010, 8'h00, 32'h12345678, 3);
        addVec(1, 4'b0000, 8'h00, 32'h12345678, -1);
        addVec(1, 4'b0101, 8'h00, 32'h12345678, 0);
        for (int i = 0; i < 2; i++) addVec(1, 4'b0000, 8'h00, 32'h12345678, -1);
        // single requester back-to-back
        for (int i = 0; i < 5; i++) addVec(1, 4'b0100, 8'h20, 32'h0BADF00D, 2);
        for (int i = 0; i < 2; i++) addVec(1, 4'b0000, 8'h00, 32'h0BADF00D, -1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rstn, vecs[i].rd, vecs[i].addr, vecs[i].inp, vecs[i].expGrant);
            checksOn = 1'b1;
        end

        // sampling edge: change during N+1 is seen, change during N+2 is not
        applyStimulus(1, 4'b0001, 8'h00, 32'h11111111, 0);
        applyStimulus(1, 4'b0000, 8'h00, 32'h22222222, -1);
        applyStimulus(1, 4'b0000, 8'h00, 32'h22222222, -1);
        applyStimulus(1, 4'b0001, 8'h00, 32'h11111111, 0);
        applyStimulus(1, 4'b0000, 8'h00, 32'h11111111, -1);
        applyStimulus(1, 4'b0000, 8'h00, 32'h22222222, -1);
        applyStimulus(1, 4'b0000, 8'h00, 32'h22222222, -1);

        // reset with reads in flight
        applyStimulus(1, 4'b0001, 8'h02, 32'h33333333, 0);
        applyStimulus(1, 4'b0010, 8'h0C, 32'h33333333, 1);
        applyStimulus(0, 4'b1010, 8'h0C, 32'h33333333, -1);
        applyStimulus(1, 4'b1010, 8'h0C, 32'h33333333, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 4'b0000, 8'h00, 32'h33333333, -1);

        checkOutput("scoreboard_drained", sbq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
